// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial n-bit adder/subtractor.
//
// Computes {cu, s} = x + (y ^ {n{k}}) + ci, one bit per clock, LSB first, through a
// single full adder and a carry flip-flop. Operands are captured on a start handshake.
// The result is held after completion until the next accepted start.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE or DONE
//   x      in   operand A (n bits)
//   y      in   operand B (n bits)
//   ci     in   carry-in
//   k      in   mode: 0 = add, 1 = subtract
//   s      out  result (n bits)
//   cu     out  carry-out
//   ov     out  signed overflow (present only with SERIAL_ADDSUB_OVF_EN defined)
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when s/cu become valid
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds the ov output and its flip-flop.

module serial_addsub #(
   parameter int unsigned n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [n-1:0] x,
   input  logic [n-1:0] y,
   input  logic         ci,
   input  logic         k,
   output logic [n-1:0] s,
   output logic         cu,
`ifdef SERIAL_ADDSUB_OVF_EN
   output logic         ov,
`endif
   output logic         busy,
   output logic         done
);

   localparam int unsigned CntW = $clog2(n) + 1;
   localparam logic [CntW-1:0] LastBit = CntW'(n - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state;
   logic [n-1:0]    a;      // operand A shift register
   logic [n-1:0]    b;      // operand B shift register, already conditioned by k
   logic            carry;  // carry between successive bit positions
   logic [CntW-1:0] cnt;    // bit position being processed

   logic sum_bit;
   logic carry_out;

   // Single full adder shared by all bit positions.
   always_comb begin
      sum_bit   = a[0] ^ b[0] ^ carry;
      carry_out = (a[0] & b[0]) | (carry & (a[0] ^ b[0]));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= StIdle;
         a     <= '0;
         b     <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         s     <= '0;
         cu    <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ov    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  // k is folded into b here, so it need not be kept separately.
                  a     <= x;
                  b     <= y ^ {n{k}};
                  carry <= ci;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
`ifdef SERIAL_ADDSUB_OVF_EN
                  ov    <= 1'b0;
`endif
               end else begin
                  state <= StIdle;
               end
            end
            StRun: begin
               a     <= a >> 1;
               b     <= b >> 1;
               s     <= {sum_bit, s[n-1:1]};
               carry <= carry_out;
               cnt   <= cnt + 1'b1;
               if (cnt == LastBit) begin
                  cu    <= carry_out;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StDone;
`ifdef SERIAL_ADDSUB_OVF_EN
                  // On the MSB cycle, carry is the carry into the MSB.
                  ov    <= carry ^ carry_out;
`endif
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
